// File: rtl/bus_fifo_slave_pkg.sv
// Shared register map, bit positions and status packing for bus_fifo_slave.
// Imported by the top level and the testbench.
package bus_fifo_slave_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_FLAG = 2'd3;

  localparam int STAT_RX_NEMPTY = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_NFULL  = 2;
  localparam int STAT_TX_EMPTY  = 3;
  localparam int STAT_RX_OVF    = 4;
  localparam int STAT_TX_OVF    = 5;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_FLUSH = 7;

  localparam int FLAG_RX_OVF = 0;
  localparam int FLAG_TX_OVF = 1;

  typedef struct packed {
    logic tx_ovf;
    logic rx_ovf;
  } flags_t;

  function automatic logic [7:0] pack_stat(input logic rx_nempty, input logic rx_full,
                                           input logic tx_nfull, input logic tx_empty,
                                           input flags_t flags);
    logic [7:0] s;
    s = '0;
    s[STAT_RX_NEMPTY] = rx_nempty;
    s[STAT_RX_FULL]   = rx_full;
    s[STAT_TX_NFULL]  = tx_nfull;
    s[STAT_TX_EMPTY]  = tx_empty;
    s[STAT_RX_OVF]    = flags.rx_ovf;
    s[STAT_TX_OVF]    = flags.tx_ovf;
    return s;
  endfunction

endpackage

// File: rtl/bus_fifo_slave_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; storage is not reset.
// Push is refused when full (even with a same-cycle pop); pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_fifo_slave.sv
// MiniRISC bus slave bridging CPU reads/writes to RX and TX byte FIFOs.
// Optional registered interrupt and CTRL enable bits under `BUS_FIFO_IRQ_EN.
module bus_fifo_slave
  import bus_fifo_slave_pkg::*;
#(
  parameter logic [7:0] BASEADDR = 8'hE0,
  parameter int         DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_mst2slv_addr,
  input  logic       s_mst2slv_wr,
  input  logic       s_mst2slv_rd,
  input  logic [7:0] s_mst2slv_data,
  output logic [7:0] s_slv2mst_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic       sel, rd_acc, wr_acc;
  logic [1:0] reg_sel;
  logic       flush;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic [CW-1:0] rx_count, tx_count;
  flags_t     flags_q, flags_d;
  logic [1:0] ctrl_ie;
  logic [7:0] rd_data;

  assign sel     = (s_mst2slv_addr[7:2] == BASEADDR[7:2]);
  assign reg_sel = s_mst2slv_addr[1:0];
  assign rd_acc  = sel & s_mst2slv_rd;
  assign wr_acc  = sel & s_mst2slv_wr;

  assign flush    = wr_acc & (reg_sel == REG_CTRL) & s_mst2slv_data[CTRL_FLUSH];
  assign rx_ready = rst & ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_acc & (reg_sel == REG_DATA);
  assign tx_push  = wr_acc & (reg_sel == REG_DATA);
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .flush (flush),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (s_mst2slv_data),
    .pop   (tx_pop),
    .flush (flush),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Sticky overflow flags; a same-cycle set beats the write-1-to-clear.
  always_comb begin
    flags_d = flags_q;
    if (wr_acc && reg_sel == REG_FLAG) begin
      if (s_mst2slv_data[FLAG_RX_OVF]) flags_d.rx_ovf = 1'b0;
      if (s_mst2slv_data[FLAG_TX_OVF]) flags_d.tx_ovf = 1'b0;
    end
    if (rx_valid && rx_full)  flags_d.rx_ovf = 1'b1;
    if (tx_push && tx_full)   flags_d.tx_ovf = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

`ifdef BUS_FIFO_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_acc && reg_sel == REG_CTRL) ctrl_d = s_mst2slv_data[1:0];
    irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & tx_empty)
          | flags_q.rx_ovf | flags_q.tx_ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl_ie = ctrl_q;
  assign irq     = irq_q;
`else
  assign ctrl_ie = 2'b00;
  assign irq     = 1'b0;
`endif

  // Read data is zero unless this slave is addressed, so it can be OR-combined.
  always_comb begin
    rd_data = 8'h00;
    if (rd_acc) begin
      case (reg_sel)
        REG_DATA: rd_data = rx_empty ? 8'h00 : rx_head;
        REG_STAT: rd_data = pack_stat(~rx_empty, rx_full, ~tx_full, tx_empty, flags_q);
        REG_CTRL: rd_data = {6'd0, ctrl_ie};
        default:  rd_data = {6'd0, flags_q.tx_ovf, flags_q.rx_ovf};
      endcase
    end
  end

  assign s_slv2mst_data = rd_data;

  logic unused_bits;
  assign unused_bits = ^{s_mst2slv_data[6:2], rx_count, tx_count};

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Directed bench for bus_fifo_slave with an expected-data queue and immediate assertions.
// Covers reset, RX/TX fill and drain, overflow, pointer wrap, flush, decode and irq.
module tb_bus_fifo_slave;
  import bus_fifo_slave_pkg::*;

  localparam logic [7:0] BASE  = 8'hE0;
  localparam int         DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] s_slv2mst_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       irq;

  logic [7:0] exp_q[$];
  int         vectors;
  int         miscompares;

  bus_fifo_slave #(.BASEADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_mst2slv_addr (addr),
    .s_mst2slv_wr   (wr),
    .s_mst2slv_rd   (rd),
    .s_mst2slv_data (wdata),
    .s_slv2mst_data (s_slv2mst_data),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .irq            (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every step starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    check(tag, {7'd0, obs}, {7'd0, expv});
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    rd   = 1'b1;
    #3;
    d = s_slv2mst_data;
    tick();
    rd = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [7:0] d);
    addr  = BASE + {6'd0, off};
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [7:0] expv);
    logic [7:0] d;
    bus_rd(BASE + {6'd0, off}, d);
    check(tag, d, expv);
  endtask

  task automatic rx_push(input logic [7:0] d, input logic expect_accept);
    rx_data  = d;
    rx_valid = 1'b1;
    if (expect_accept) exp_q.push_back(d);
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; addr = 8'h00; wr = 1'b0; rd = 1'b0; wdata = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_rdata", s_slv2mst_data, 8'h00);
    check_bit("rst_rx_ready", rx_ready, 1'b0);
    check_bit("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check_bit("rst_irq", irq, 1'b0);
    rst = 1'b1;
    tick();
    check_bit("rx_ready_after_rst", rx_ready, 1'b1);
    rd_chk("stat_reset", REG_STAT, 8'h0C);

    // RX fill past full, then drain in order
    for (int i = 0; i < DEPTH + 1; i++) begin
      rx_data  = 8'(16 + i);
      rx_valid = 1'b1;
      check_bit("rx_ready_fill", rx_ready, (i < DEPTH));
      if (i < DEPTH) exp_q.push_back(rx_data);
      tick();
    end
    rx_valid = 1'b0;
    check_bit("rx_ready_full", rx_ready, 1'b0);
    rd_chk("stat_rx_full", REG_STAT, 8'h1F);
    rd_chk("flag_rx_ovf", REG_FLAG, 8'h01);
    for (int i = 0; i < DEPTH; i++) rd_chk("rx_drain", REG_DATA, exp_q.pop_front());
    rd_chk("rx_empty_rd", REG_DATA, 8'h00);
    rd_chk("stat_rx_empty", REG_STAT, 8'h1C);

    // TX write, hold, then drain
    tx_ready = 1'b0;
    bus_wr(REG_DATA, 8'hA5); exp_q.push_back(8'hA5);
    bus_wr(REG_DATA, 8'h5A); exp_q.push_back(8'h5A);
    check_bit("tx_valid_held", tx_valid, 1'b1);
    check("tx_head_held", tx_data, exp_q[0]);
    rd_chk("stat_tx_two", REG_STAT, 8'h14);
    tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_bit("tx_valid_drain", tx_valid, 1'b1);
      check("tx_drain", tx_data, exp_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    check_bit("tx_valid_empty", tx_valid, 1'b0);
    check("tx_data_empty", tx_data, 8'h00);

    // TX overflow: ninth write discarded
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(48 + i));
      bus_wr(REG_DATA, 8'(48 + i));
    end
    rd_chk("stat_tx_full", REG_STAT, 8'h30);
    rd_chk("flag_both_ovf", REG_FLAG, 8'h03);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("tx_ovf_drain", tx_data, exp_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    check_bit("tx_valid_after_ovf", tx_valid, 1'b0);

    // Simultaneous push/pop over 3*DEPTH bytes, count held at 3
    for (int i = 0; i < 3; i++) rx_push(8'(64 + i), 1'b1);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rx_data  = 8'($urandom_range(0, 255));
      rx_valid = 1'b1;
      exp_q.push_back(rx_data);
      bus_rd(BASE + {6'd0, REG_DATA}, d);
      check("simul_rd", d, exp_q.pop_front());
    end
    rx_valid = 1'b0;
    rd_chk("stat_simul", REG_STAT, 8'h3D);
    for (int i = 0; i < 3; i++) rd_chk("simul_tail", REG_DATA, exp_q.pop_front());
    rd_chk("simul_empty", REG_DATA, 8'h00);

    // Flush overrides a same-cycle RX push; flags survive
    for (int i = 0; i < 5; i++) rx_push(8'(80 + i), 1'b1);
    addr = BASE + {6'd0, REG_CTRL}; wdata = 8'h80; wr = 1'b1;
    rx_data = 8'h99; rx_valid = 1'b1;
    tick();
    wr = 1'b0; rx_valid = 1'b0;
    exp_q.delete();
    rd_chk("stat_flush", REG_STAT, 8'h3C);
    rd_chk("ctrl_after_flush", REG_CTRL, 8'h00);
    rd_chk("data_after_flush", REG_DATA, 8'h00);
    bus_wr(REG_FLAG, 8'h01);
    rd_chk("flag_clr_rx", REG_FLAG, 8'h02);
    rd_chk("stat_clr_rx", REG_STAT, 8'h2C);
    bus_wr(REG_FLAG, 8'h02);
    rd_chk("flag_clr_tx", REG_FLAG, 8'h00);

    // Set wins over same-cycle clear
    for (int i = 0; i < DEPTH; i++) rx_push(8'(96 + i), 1'b1);
    addr = BASE + {6'd0, REG_FLAG}; wdata = 8'h01; wr = 1'b1;
    rx_data = 8'hEE; rx_valid = 1'b1;
    tick();
    wr = 1'b0; rx_valid = 1'b0;
    rd_chk("flag_set_wins", REG_FLAG, 8'h01);
    bus_wr(REG_DATA, 8'h77);
    bus_wr(REG_CTRL, 8'h80);
    exp_q.delete();
    check_bit("tx_flushed", tx_valid, 1'b0);
    bus_wr(REG_FLAG, 8'h01);
    rd_chk("stat_clean", REG_STAT, 8'h0C);

    // Decode: BASEADDR+4 is not ours
    rx_push(8'h66, 1'b1);
    bus_rd(BASE + 8'd4, d);
    check("off_window_rd", d, 8'h00);
    addr = BASE + 8'd4; wdata = 8'h80; wr = 1'b1;
    tick();
    wr = 1'b0;
    check_bit("off_window_no_tx", tx_valid, 1'b0);
    rd_chk("off_window_stat", REG_STAT, 8'h0D);
    rd_chk("off_window_data", REG_DATA, exp_q.pop_front());

    // Interrupt
`ifdef BUS_FIFO_IRQ_EN
    bus_wr(REG_CTRL, 8'h01);
    rd_chk("ctrl_rx_ie", REG_CTRL, 8'h01);
    check_bit("irq_idle", irq, 1'b0);
    rx_push(8'h77, 1'b1);
    check_bit("irq_push_edge", irq, 1'b0);
    tick();
    check_bit("irq_raised", irq, 1'b1);
    rd_chk("irq_pop", REG_DATA, exp_q.pop_front());
    check_bit("irq_pop_edge", irq, 1'b1);
    tick();
    check_bit("irq_dropped", irq, 1'b0);
    bus_wr(REG_CTRL, 8'h00);
`else
    bus_wr(REG_CTRL, 8'h03);
    rd_chk("ctrl_not_stored", REG_CTRL, 8'h00);
    rx_push(8'h77, 1'b1);
    tick();
    check_bit("irq_tied_low", irq, 1'b0);
    rd_chk("irq_pop", REG_DATA, exp_q.pop_front());
`endif

    // Reset in mid-transfer
    rx_push(8'h12, 1'b1);
    rx_push(8'h34, 1'b1);
    bus_wr(REG_DATA, 8'h56);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_bit("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    rd_chk("midrst_stat", REG_STAT, 8'h0C);
    rd_chk("midrst_data", REG_DATA, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
